// File: rtl/data_mem_pkg.sv
// Shared types for the byte-addressed data memory: access size codes,
// handshake FSM states and a helper returning bytes per access.
package data_mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum {IDLE, WAIT, RESP} mem_state_e;

    // Illegal codes report 1 byte; they are rejected separately.
    function automatic logic [2:0] size_bytes(input mem_size_e size);
        case (size)
            MEM_H, MEM_HU: size_bytes = 3'd4 >> 1;
            MEM_W:         size_bytes = 3'd4;
            default:       size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for 32-bit little-endian word storage.
// Ports: funct3/offset select the access; wdata/rword are the right-aligned
// store data and the raw stored word; byte_en/wdata_lane/rdata_ext are the
// byte strobes, lane-replicated store data and the extended load result.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = '0;
        case (funct3)
            MEM_B: begin
                byte_en    = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_BU: begin
                rdata_ext = {24'h0, shifted[7:0]};
            end
            MEM_H: begin
                byte_en    = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_HU: begin
                rdata_ext = {16'h0, shifted[15:0]};
            end
            MEM_W: begin
                byte_en   = 4'b1111;
                rdata_ext = shifted;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response handshakes, RV32I load/store sizing and error detection.
// Ports: clk, rst_n (async, active low); req_valid/req_ready/req_write/
// req_funct3/req_addr/req_wdata request; resp_valid/resp_ready/resp_rdata/
// resp_err response. Optional macro DATA_MEM_INIT_EN zeroes the array
// in simulation.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DEPTH_BYTES   = 131072,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          READ_LATENCY  = 1,
    parameter string       INIT_FILE     = "",
    parameter logic [31:0] INIT_OFFSET   = 32'h10000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err
);

    localparam int XW    = ADDRESS_WIDTH + 1;
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [XW-1:0] BASE_X  = XW'(BASE_ADDR);
    localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH_BYTES);
    localparam logic [2:0]    LAST_CNT = 3'(READ_LATENCY - 1);

    logic [7:0]  mem [DEPTH_BYTES];
    mem_state_e  state;
    logic [2:0]  cnt;
    logic [32:0] pipe [READ_LATENCY];

    logic              accept;
    logic              err;
    logic              misalign;
    logic              bad_f3;
    logic              out_range;
    logic [XW-1:0]     off;
    logic [XW-1:0]     last;
    logic [IDX_W-3:0]  wbase;
    logic [31:0]       rword;
    logic [31:0]       wlane;
    logic [31:0]       rext;
    logic [3:0]        be;

    assign accept = req_valid && req_ready;

    // Extra top bit keeps addresses near the top of the space from
    // wrapping back into the mapped window.
    assign off  = {1'b0, req_addr} - BASE_X;
    assign last = off + XW'(size_bytes(mem_size_e'(req_funct3))) - XW'(1);

    assign out_range = ({1'b0, req_addr} < BASE_X) || (last >= DEPTH_X);

    always_comb begin
        misalign = 1'b0;
        bad_f3   = 1'b0;
        case (req_funct3)
            MEM_B, MEM_BU: misalign = 1'b0;
            MEM_H, MEM_HU: misalign = req_addr[0];
            MEM_W:         misalign = |req_addr[1:0];
            default:       bad_f3   = 1'b1;
        endcase
    end

    // Unsigned sizes have no store form.
    assign err = misalign | bad_f3 | out_range | (req_write & req_funct3[2]);

    assign wbase = off[IDX_W-1:2];
    assign rword = {mem[{wbase, 2'd3}], mem[{wbase, 2'd2}],
                    mem[{wbase, 2'd1}], mem[{wbase, 2'd0}]};

    mem_lane_align u_align (
        .funct3     (req_funct3),
        .offset     (off[1:0]),
        .wdata      (req_wdata),
        .rword      (rword),
        .byte_en    (be),
        .wdata_lane (wlane),
        .rdata_ext  (rext)
    );

    always_ff @(posedge clk) begin
        if (accept && req_write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[{wbase, 2'(b)}] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= (READ_LATENCY > 1) ? WAIT : RESP;
                        cnt   <= (READ_LATENCY > 1) ? 3'd1 : 3'd0;
                    end
                end
                WAIT: begin
                    if (cnt >= LAST_CNT) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 captures {err, data} at accept; the remaining stages shift
    // once per WAIT cycle so the last stage is full on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else if (accept) begin
            if (err) begin
                pipe[0] <= {1'b1, 32'h0};
            end else begin
                pipe[0] <= {1'b0, req_write ? 32'h0 : rext};
            end
        end else if (state == WAIT) begin
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & pipe[READ_LATENCY-1][32];
    assign resp_rdata = resp_valid ? pipe[READ_LATENCY-1][31:0] : 32'h0;

`ifdef DATA_MEM_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem[i] = 8'h00;
        end
    end
`else
    if (INIT_FILE != "" && INIT_OFFSET >= 32'(DEPTH_BYTES)) begin : g_init_warn
        $warning("data_mem: image ignored without DATA_MEM_INIT_EN");
    end
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_mem: READ_LATENCY must be 1..4");
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: one instance at READ_LATENCY 1 and one at 3,
// selected by sel, sharing stimulus and a muxed view of their outputs.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_ready = 1'b1;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(rdy0),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready),
        .resp_rdata(rd0), .resp_err(er0)
    );

    data_mem #(.READ_LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(rdy1),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready),
        .resp_rdata(rd1), .resp_err(er1)
    );

    assign req_ready  = sel ? rdy1 : rdy0;
    assign resp_valid = sel ? rv1 : rv0;
    assign resp_rdata = sel ? rd1 : rd0;
    assign resp_err   = sel ? er1 : er0;

    task automatic txn(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = a; req_wdata = wd; resp_ready = 1'b1;
        @(posedge clk);
        lat = 0; rd = 'x; er = 1'bx;
        while (lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL txn_timeout: resp_valid %b after %0d cycles, want 1",
                     resp_valid, lat);
        end else begin
            rd = resp_rdata; er = resp_err;
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'h0}) begin
                errors++;
                $display("FAIL reset_state sel=%0d: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                         s, req_ready, resp_valid, resp_err, resp_rdata);
            end
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_load(input logic s, input int exp_lat);
        logic [31:0] rd; logic er; int lat;
        sel = s;
        txn(1'b1, 3'b010, 32'h10000, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0 || lat != exp_lat) begin
            errors++;
            $display("FAIL sw_resp sel=%0d: got err=%b rd=%h lat=%0d want 0 0 %0d",
                     s, er, rd, lat, exp_lat);
        end
        txn(1'b0, 3'b010, 32'h10000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF || lat != exp_lat) begin
            errors++;
            $display("FAIL lw_resp sel=%0d: got err=%b rd=%h lat=%0d want 0 deadbeef %0d",
                     s, er, rd, lat, exp_lat);
        end
    endtask

    task automatic test_sizes();
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        logic [31:0] ad [5] = '{32'h10000, 32'h10000, 32'h10002, 32'h10002, 32'h10000};
        logic [31:0] ex [5] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFDEAD,
                               32'h0000DEAD, 32'hFFFFBEEF};
        logic [31:0] rd; logic er; int lat;
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            txn(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
            checks++;
            if (er !== 1'b0 || rd !== ex[i]) begin
                errors++;
                $display("FAIL size_load %0d f3=%b: got err=%b rd=%h want 0 %h",
                         i, f3[i], er, rd, ex[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er; int lat;
        sel = 1'b0;
        txn(1'b1, 3'b000, 32'h10001, 32'hFFFFFF12, rd, er, lat);
        txn(1'b0, 3'b010, 32'h10000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD12EF) begin
            errors++;
            $display("FAIL sb_lanes: got err=%b rd=%h want 0 dead12ef", er, rd);
        end
    endtask

    task automatic test_errors();
        logic        wr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3 [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b000};
        logic [31:0] ad [7] = '{32'h10002, 32'h10001, 32'h1FFFE, 32'h10000,
                               32'h10000, 32'h20000, 32'hFFFFFFFF};
        logic [31:0] rd; logic er; int lat;
        sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            txn(wr[i], f3[i], ad[i], 32'h11111111, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err_case %0d: got err=%b rd=%h want 1 00000000",
                         i, er, rd);
            end
        end
        txn(1'b0, 3'b010, 32'h10000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD12EF) begin
            errors++;
            $display("FAIL err_readback: got err=%b rd=%h want 0 dead12ef", er, rd);
        end
    endtask

    task automatic test_top_boundary();
        logic [31:0] rd; logic er; int lat;
        sel = 1'b0;
        txn(1'b1, 3'b010, 32'h1FFFC, 32'hCAFEF00D, rd, er, lat);
        txn(1'b0, 3'b100, 32'h1FFFF, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h000000CA) begin
            errors++;
            $display("FAIL top_lbu: got err=%b rd=%h want 0 000000ca", er, rd);
        end
        txn(1'b0, 3'b001, 32'h1FFFE, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hFFFFCAFE) begin
            errors++;
            $display("FAIL top_lh: got err=%b rd=%h want 0 ffffcafe", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10000; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD12EF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold %0d: got vld=%b rd=%h rdy=%b want 1 dead12ef 0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            if (i == 2) begin
                req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        txn(1'b0, 3'b010, 32'h10000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD12EF) begin
            errors++;
            $display("FAIL hold_readback: got err=%b rd=%h want 0 dead12ef", er, rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        sel = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10000; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_busy: got rdy=%b want 0", req_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abandoned %0d: got vld=%b want 0", i, resp_valid);
            end
        end
        txn(1'b0, 3'b010, 32'h10000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF || lat != 3) begin
            errors++;
            $display("FAIL post_reset_lw: got err=%b rd=%h lat=%0d want 0 deadbeef 3",
                     er, rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_store_load(1'b0, 1);
        test_store_load(1'b1, 3);
        test_sizes();
        test_byte_store();
        test_errors();
        test_top_boundary();
        test_backpressure();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
